// File: rtl/loader_pkg.sv
// Shared constants and FSM state encoding for the UART hex loader.
package loader_pkg;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] DOT = 8'h2E;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ECHO = 1'b1
    } state_t;

endpackage

// File: rtl/hex_nib_decode.sv
// Combinational ASCII hex character to nibble decoder ('0'-'9', 'A'-'F', 'a'-'f').
module hex_nib_decode (
    input  logic [7:0] ch,
    output logic       valid,
    output logic [3:0] nib
);

    // Digits map straight from the low nibble; letters A-F/a-f have low nibble 1..6, so add 9.
    always_comb begin
        valid = 1'b0;
        nib   = 4'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            valid = 1'b1;
            nib   = ch[3:0];
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            valid = 1'b1;
            nib   = ch[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_hex_loader.sv
// Byte-stream hex loader: assembles ASCII hex characters into words and emits
// one-cycle write strobes to an external memory, optionally echoing every byte.
module uart_hex_loader
    import loader_pkg::*;
#(
    parameter  int WORD_W = 32,
    parameter  int DEPTH  = 16,
    parameter  int ECHO   = 1,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int NIB_N  = WORD_W / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   word_cnt,
    output logic              full,
    output logic              overflow,
    output logic              done
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int NIB_CW = $clog2(NIB_N);
    localparam logic [NIB_CW-1:0] NIB_LAST = NIB_CW'(NIB_N - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    state_t              state_reg;
    logic                run_reg;
    logic [7:0]          tx_data_reg;
    logic [WORD_W-1:0]   sr_reg;
    logic [NIB_CW-1:0]   nib_cnt_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]    word_cnt_reg;
    logic                overflow_reg;
    logic                done_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [WORD_W-1:0]   mem_wdata_reg;

    logic                hex_valid;
    logic [3:0]          hex_nib;
    logic [WORD_W-1:0]   sr_shift;
    logic                accept;

    hex_nib_decode u_dec (
        .ch    (rx_data),
        .valid (hex_valid),
        .nib   (hex_nib)
    );

    assign sr_shift  = {sr_reg[WORD_W-5:0], hex_nib};
    assign rx_ready  = en && (state_reg == S_IDLE) && !clr && run_reg;
    assign accept    = rx_valid && rx_ready;
    assign tx_data   = tx_data_reg;
    assign tx_valid  = (state_reg == S_ECHO);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign word_cnt  = word_cnt_reg;
    assign full      = (word_cnt_reg == CNT_FULL);
    assign overflow  = overflow_reg;
    assign done      = done_reg;

    // Reset release is registered once so no byte is taken on the first edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_reg <= 1'b0;
        else        run_reg <= 1'b1;
    end

    // Echo FSM: latch the accepted byte and hold it until the transmitter takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            tx_data_reg <= 8'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept && (ECHO != 0)) begin
                        tx_data_reg <= rx_data;
                        state_reg   <= S_ECHO;
                    end
                end
                S_ECHO: begin
                    if (tx_ready) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Word assembly, write strobe generation and status flags; clr overrides any accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg        <= '0;
            nib_cnt_reg   <= '0;
            wr_ptr_reg    <= '0;
            word_cnt_reg  <= '0;
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            if (clr) begin
                sr_reg       <= '0;
                nib_cnt_reg  <= '0;
                wr_ptr_reg   <= '0;
                word_cnt_reg <= '0;
                overflow_reg <= 1'b0;
                done_reg     <= 1'b0;
            end else if (accept) begin
                if (rx_data == LF || rx_data == CR) begin
                    nib_cnt_reg <= '0;
                end else if (rx_data == DOT) begin
                    done_reg    <= 1'b1;
                    nib_cnt_reg <= '0;
                end else if (hex_valid && !done_reg) begin
                    sr_reg <= sr_shift;
                    if (nib_cnt_reg == NIB_LAST) begin
                        nib_cnt_reg <= '0;
                        if (full) begin
                            // Memory already holds DEPTH words: flag it, never wrap.
                            overflow_reg <= 1'b1;
                        end else begin
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= wr_ptr_reg;
                            mem_wdata_reg <= sr_shift;
                            wr_ptr_reg    <= wr_ptr_reg + ADDR_W'(1);
                            word_cnt_reg  <= word_cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        nib_cnt_reg <= nib_cnt_reg + NIB_CW'(1);
                    end
                end
            end
        end
    end

endmodule
